// File: rtl/panel_key_arbiter_pkg.sv
// Shared definitions for the PDP-8/I front-panel key arbiter:
// key indices, default masks and the grant FSM state type.
package panel_pkg;

  localparam int unsigned KEY_STOP     = 0;
  localparam int unsigned KEY_CONT     = 1;
  localparam int unsigned KEY_START    = 2;
  localparam int unsigned KEY_LOAD_ADD = 3;
  localparam int unsigned KEY_DEP      = 4;
  localparam int unsigned KEY_EXAM     = 5;

  localparam int unsigned NKEYS_DEFAULT = 6;

  // Only STOP is honoured while the CPU runs; DEP/EXAM may auto-repeat.
  localparam logic [5:0] RUN_MASK_DEFAULT    = 6'(1 << KEY_STOP);
  localparam logic [5:0] REPEAT_MASK_DEFAULT = 6'((1 << KEY_DEP) | (1 << KEY_EXAM));

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RELEASE
  } panel_state_e;

endpackage

// File: rtl/panel_key_arbiter_if.sv
// Key-operation request handshake between the panel arbiter (master)
// and the CPU manual-function sequencer (slave).
interface panel_key_arbiter_if
  import panel_pkg::*;
#(
  parameter int unsigned NKEYS = NKEYS_DEFAULT
);

  logic                     req_valid;
  logic [$clog2(NKEYS)-1:0] req_key;
  logic                     req_ack;

  modport master (output req_valid, output req_key, input req_ack);
  modport slave  (input req_valid, input req_key, output req_ack);

endinterface

// File: rtl/panel_key_arbiter_debounce.sv
// Single-key up/down-counter debouncer with hysteresis: level rises when the
// count saturates at DEBOUNCE_CYCLES and falls only when it decays to zero.
module panel_key_arbiter_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 5000000
) (
  input  logic clk,
  input  logic rst,
  input  logic sample,
  output logic level
);

  localparam int unsigned    CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  CMAX = CW'(DEBOUNCE_CYCLES);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;

  always_comb begin
    cnt_n = cnt;
    if (sample && cnt != CMAX)
      cnt_n = cnt + 1'b1;
    else if (!sample && cnt != '0)
      cnt_n = cnt - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      cnt <= cnt_n;
      if (cnt_n == CMAX)
        level <= 1'b1;
      else if (cnt_n == '0)
        level <= 1'b0;
    end
  end

endmodule

// File: rtl/panel_key_arbiter.sv
// Front-panel momentary-key arbiter: synchronise, debounce, grant one key
// press at a time, then lock out until all keys release.
// Optional auto-repeat of a held key: define PANEL_KEY_AUTOREPEAT_EN.
module panel_key_arbiter
  import panel_pkg::*;
#(
  parameter int unsigned      NKEYS           = NKEYS_DEFAULT,
  parameter int unsigned      DEBOUNCE_CYCLES = 5000000,
  parameter logic [NKEYS-1:0] RUN_MASK        = RUN_MASK_DEFAULT
`ifdef PANEL_KEY_AUTOREPEAT_EN
  ,
  parameter int unsigned      REPEAT_CYCLES   = 25000000,
  parameter logic [NKEYS-1:0] REPEAT_MASK     = REPEAT_MASK_DEFAULT
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NKEYS-1:0]   key_raw,
  input  logic               run,
  panel_key_arbiter_if.master req,
  output logic               lockout,
  output logic [NKEYS-1:0]   key_db
);

  localparam int unsigned KW = $clog2(NKEYS);

  logic [NKEYS-1:0] sync1, sync2, key_db_q;
  logic [NKEYS-1:0] press, elig;
  panel_state_e     state, state_n;
  logic             valid_r, valid_n, lock_n;
  logic [KW-1:0]    key_r, key_n;

  for (genvar g = 0; g < NKEYS; g++) begin : g_db
    panel_key_arbiter_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk    (clk),
      .rst    (rst),
      .sample (sync2[g]),
      .level  (key_db[g])
    );
  end

  assign press = key_db & ~key_db_q;
  assign elig  = press & (run ? RUN_MASK : '1);

`ifdef PANEL_KEY_AUTOREPEAT_EN
  localparam int unsigned RW = $clog2(REPEAT_CYCLES + 1);

  logic [RW-1:0] rep_cnt;
  logic          rep_hold, rep_fire;

  // Exactly the last granted key held alone, and that key is repeatable.
  assign rep_hold = (state == RELEASE) && (key_db == (NKEYS'(1) << key_r)) && REPEAT_MASK[key_r];
  assign rep_fire = rep_hold && (rep_cnt == RW'(REPEAT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || !rep_hold || (key_db != key_db_q) || rep_fire)
      rep_cnt <= '0;
    else
      rep_cnt <= rep_cnt + 1'b1;
  end
`endif

  always_comb begin
    state_n = state;
    valid_n = valid_r;
    key_n   = key_r;
    lock_n  = lockout;
    unique case (state)
      IDLE: begin
        if (elig != '0) begin
          // Descending scan so the lowest set index wins.
          for (int unsigned i = NKEYS; i > 0; i--)
            if (elig[i-1]) key_n = KW'(i - 1);
          valid_n = 1'b1;
          state_n = REQ;
        end
      end
      REQ: begin
        if (req.req_ack) begin
          valid_n = 1'b0;
          lock_n  = 1'b1;
          state_n = RELEASE;
        end
      end
      RELEASE: begin
        if (key_db == '0) begin
          lock_n  = 1'b0;
          state_n = IDLE;
        end
`ifdef PANEL_KEY_AUTOREPEAT_EN
        else if (rep_fire) begin
          valid_n = 1'b1;
          lock_n  = 1'b0;
          state_n = REQ;
        end
`endif
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1    <= '0;
      sync2    <= '0;
      key_db_q <= '0;
      state    <= IDLE;
      valid_r  <= 1'b0;
      key_r    <= '0;
      lockout  <= 1'b0;
    end else begin
      sync1    <= key_raw;
      sync2    <= sync1;
      key_db_q <= key_db;
      state    <= state_n;
      valid_r  <= valid_n;
      key_r    <= key_n;
      lockout  <= lock_n;
    end
  end

  assign req.req_valid = valid_r;
  assign req.req_key   = key_r;

endmodule

// File: tb/tb_panel_key_arbiter.sv
// Scoreboard bench for panel_key_arbiter: expected grants are queued at
// key press and compared when req_valid rises.
module tb_panel_key_arbiter;
  import panel_pkg::*;

  localparam int unsigned NK = 6;
  localparam int unsigned DB = 4;
  localparam int unsigned RC = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NK-1:0] key_raw = '0;
  logic          run = 1'b0;
  logic          lockout;
  logic [NK-1:0] key_db;

  panel_key_arbiter_if #(.NKEYS(NK)) bus ();

  panel_key_arbiter #(
    .NKEYS          (NK),
    .DEBOUNCE_CYCLES(DB),
    .RUN_MASK       (6'b000001)
`ifdef PANEL_KEY_AUTOREPEAT_EN
    ,
    .REPEAT_CYCLES  (RC),
    .REPEAT_MASK    (6'b110000)
`endif
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .key_raw(key_raw),
    .run    (run),
    .req    (bus.master),
    .lockout(lockout),
    .key_db (key_db)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, want);
  endtask

  logic       prev_valid = 1'b0;
  logic [2:0] prev_key   = '0;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.req_valid && !prev_valid) begin
        if (exp_q.size() > 0) check("req_key", 32'(bus.req_key), 32'(exp_q.pop_front()));
        else                  check("spurious_req", 1, 0);
      end else if (bus.req_valid && prev_valid) begin
        check("key_stable", 32'(bus.req_key), 32'(prev_key));
      end
    end
    prev_valid = bus.req_valid;
    prev_key   = bus.req_key;
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_db(input int idx, input logic val, input int max, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (key_db[idx] !== val && n < max);
    if (key_db[idx] !== val) check($sformatf("db%0d_timeout", idx), 32'(key_db[idx]), 32'(val));
  endtask

  task automatic wait_valid(input int max, output int n);
    n = 0;
    while (bus.req_valid !== 1'b1 && n < max) begin
      @(negedge clk);
      n++;
    end
    if (bus.req_valid !== 1'b1) check("valid_timeout", 32'(bus.req_valid), 1);
  endtask

  task automatic do_ack();
    bus.req_ack = 1'b1;
    @(negedge clk);
    bus.req_ack = 1'b0;
    check("ack_drop", 32'(bus.req_valid), 0);
    check("ack_lock", 32'(lockout), 1);
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while ((key_db !== '0 || lockout !== 1'b0) && n < max) begin
      @(negedge clk);
      n++;
    end
    check("idle_lock", 32'(lockout), 0);
    check("idle_valid", 32'(bus.req_valid), 0);
  endtask

  initial begin
    int n;
    bus.req_ack = 1'b0;
    tick(3);
    check("rst_valid", 32'(bus.req_valid), 0);
    check("rst_key", 32'(bus.req_key), 0);
    check("rst_lock", 32'(lockout), 0);
    check("rst_db", 32'(key_db), 0);
    rst = 1'b0;
    tick();

    // DEP press: debounce latency, grant latency, lockout
    key_raw[KEY_DEP] = 1'b1;
    exp_q.push_back(KEY_DEP);
    wait_db(KEY_DEP, 1'b1, 20, n);
    check("db_rise_lat", n, 2 + DB);
    check("pre_valid", 32'(bus.req_valid), 0);
    tick();
    check("lat_valid", 32'(bus.req_valid), 1);
    check("lat_key", 32'(bus.req_key), KEY_DEP);
    tick(2);
    do_ack();
    key_raw[KEY_DEP] = 1'b0;
    wait_db(KEY_DEP, 1'b0, 20, n);
    check("db_fall_lat", n, 2 + DB);
    check("lock_hold", 32'(lockout), 1);
    tick();
    check("lock_clear", 32'(lockout), 0);

    // simultaneous LOAD_ADD and EXAM
    key_raw = 6'b101000;
    exp_q.push_back(KEY_LOAD_ADD);
    wait_valid(20, n);
    check("dual_key", 32'(bus.req_key), KEY_LOAD_ADD);
    tick();
    do_ack();
    key_raw = '0;
    wait_idle(30);
    tick(5);

    // run=1 gating: START ignored, STOP granted
    run = 1'b1;
    key_raw[KEY_START] = 1'b1;
    wait_db(KEY_START, 1'b1, 20, n);
    tick(3);
    check("run_gate", 32'(bus.req_valid), 0);
    check("run_gate_lock", 32'(lockout), 0);
    key_raw[KEY_START] = 1'b0;
    wait_db(KEY_START, 1'b0, 20, n);
    key_raw[KEY_STOP] = 1'b1;
    exp_q.push_back(KEY_STOP);
    wait_valid(20, n);
    do_ack();
    key_raw[KEY_STOP] = 1'b0;
    wait_idle(30);
    run = 1'b0;

    // glitch rejection, then a press during REQ is discarded
    key_raw[KEY_CONT] = 1'b1;
    tick(2);
    key_raw[KEY_CONT] = 1'b0;
    tick(10);
    check("glitch_db", 32'(key_db[KEY_CONT]), 0);
    check("glitch_valid", 32'(bus.req_valid), 0);
    key_raw[KEY_EXAM] = 1'b1;
    exp_q.push_back(KEY_EXAM);
    wait_valid(20, n);
    key_raw[KEY_CONT] = 1'b1;
    wait_db(KEY_CONT, 1'b1, 20, n);
    tick(2);
    check("req_hold_key", 32'(bus.req_key), KEY_EXAM);
    do_ack();
    tick(5);
    check("held_lock", 32'(lockout), 1);
    key_raw = '0;
    wait_idle(30);

    // reset during REQ with the key still held
    key_raw[KEY_DEP] = 1'b1;
    exp_q.push_back(KEY_DEP);
    wait_valid(20, n);
    tick();
    rst = 1'b1;
    tick();
    check("mid_rst_valid", 32'(bus.req_valid), 0);
    check("mid_rst_key", 32'(bus.req_key), 0);
    check("mid_rst_lock", 32'(lockout), 0);
    check("mid_rst_db", 32'(key_db), 0);
    rst = 1'b0;
    exp_q.push_back(KEY_DEP);
    wait_valid(30, n);
    check("rerequest_key", 32'(bus.req_key), KEY_DEP);
    do_ack();
    key_raw = '0;
    wait_idle(30);

`ifdef PANEL_KEY_AUTOREPEAT_EN
    key_raw[KEY_DEP] = 1'b1;
    exp_q.push_back(KEY_DEP);
    wait_valid(20, n);
    do_ack();
    exp_q.push_back(KEY_DEP);
    wait_valid(30, n);
    check("repeat_lat", n, RC);
    check("repeat_lock", 32'(lockout), 0);
    do_ack();
    key_raw = '0;
    wait_idle(30);
    key_raw[KEY_START] = 1'b1;
    exp_q.push_back(KEY_START);
    wait_valid(20, n);
    do_ack();
    tick(3 * RC);
    check("no_repeat_lock", 32'(lockout), 1);
    key_raw = '0;
    wait_idle(30);
`else
    key_raw[KEY_DEP] = 1'b1;
    exp_q.push_back(KEY_DEP);
    wait_valid(20, n);
    do_ack();
    tick(3 * RC);
    check("no_repeat_lock", 32'(lockout), 1);
    key_raw = '0;
    wait_idle(30);
`endif

    tick(5);
    check("sb_empty", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
